btb_assoc: RTL
==============

// Module: btb_assoc
// PURPOSE
//  N-way set-associative branch target buffer with CTR_W-bit saturating
//  direction counters and round-robin replacement. Sits beside the fetch
//  PC mux: predicts next PC in IF, carries prediction metadata IF->ID->EX,
//  resolves in EX and raises a redirect on any direction or target
//  mismatch. Also keeps saturating branch and mispredict performance counters.
// PARAMETERS
//  SET_ADDR_LEN  6   index bits; SETS = 1<<SET_ADDR_LEN
//  WAYS          2   associativity; power of 2, >=1
//  CTR_W         2   direction counter width, >=1
//  CNT_W         32  performance counter width
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst_n          in   1      asynchronous, active-low reset
//  pc_f           in   32     fetch PC
//  stall          in   1      hold pipeline regs, suppress all updates
//  flush          in   1      clear ID/EX prediction metadata
//  br_type_e      in   3      nonzero = branch/jump resolving in EX
//  br_taken_e     in   1      actual direction in EX
//  br_target_e    in   32     actual taken target in EX
//  pred_taken_f   out  1      predict taken for pc_f
//  pred_target_f  out  32     predicted next PC for pc_f
//  pc_e           out  32     PC of the instruction in EX
//  redirect_e     out  1      mispredict: refetch from redirect_pc_e
//  redirect_pc_e  out  32     correct next PC
//  br_cnt         out  CNT_W  resolved branches (saturating)
//  miss_cnt       out  CNT_W  redirects (saturating)
// BEHAVIOUR
//  - Index = pc[SET_ADDR_LEN+1:2]; tag = pc[31:SET_ADDR_LEN+2]; pc[1:0] ignored.
//  - Lookup (comb.): hit = some way valid && tag match; at most one way hits.
//    pred_taken_f = hit && ctr[CTR_W-1]; pred_target_f = pred_taken_f ?
//    stored target : pc_f+4. Lookup reads pre-update array contents.
//  - Pipeline ID, EX regs: {pc, hit, way, ctr, pred_taken, pred_target}.
//    !stall: advance one stage; flush clears hit/pred_taken in ID and EX,
//    pc still advances. stall: all regs hold.
//  - EX: act = br_taken_e ? br_target_e : pc_e+4; prd = pred_taken_e ?
//    pred_target_e : pc_e+4. redirect_e = !stall && (act != prd) when
//    br_type_e!=0; when br_type_e==0, redirect_e = !stall && pred_taken_e
//    (false hit) with redirect_pc_e = pc_e+4. redirect_pc_e = act otherwise.
//  - Update at posedge, only when !stall && br_type_e!=0:
//    hit: ctr +1 on taken / -1 on not-taken, saturating at all-ones/0;
//    target <= br_target_e if taken. Miss && taken: allocate victim = lowest
//    invalid way, else rr_ptr[set], then rr_ptr[set] +1 mod WAYS; write
//    valid, tag, target, ctr = 1<<(CTR_W-1) (weakly taken). Miss &&
//    not-taken: no allocation. False hit: entry untouched.
//  - br_cnt +1 per resolved branch; miss_cnt +1 per redirect_e cycle;
//    both saturate at all-ones.
//  - Reset (async): all valid/ctr/rr_ptr/pipeline regs/perf counters = 0;
//    pred_taken_f=0, pred_target_f=pc_f+4, pc_e=0, redirect_e=0,
//    redirect_pc_e=4. Reset mid-operation drops all entries; no partial write.
// TESTING
//  1 reset; pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104; EX taken
//    0x100->0x80 -> redirect_e=1, redirect_pc_e=0x80; refetch 0x100 ->
//    pred_taken_f=1, pred_target_f=0x80.
//  2 CTR_W=2, 0x100 taken x3 -> ctr=3; not-taken -> redirect to 0x104,
//    ctr=2, still predicts taken; 2 more not-taken -> ctr=0, pred_taken_f=0.
//  3 hit predicting 0x80, actual taken 0xC0 -> redirect_pc_e=0xC0;
//    next lookup pred_target_f=0xC0.
//  4 WAYS=2: taken branches at 0x100, 0x200, 0x300 (same set) -> 0x300
//    evicts way0 (0x100); 0x200, 0x300 hit, 0x100 misses.
//  5 stall held 3 cycles with branch in EX -> redirect_e=0, no update,
//    br_cnt unchanged; release -> exactly one update, br_cnt +1; flush with
//    predicted-taken in EX -> no redirect for non-branch bubble.
//  6 CNT_W=4: 20 mispredicted branches -> br_cnt=miss_cnt=15 (saturated).

Source files
------------

// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative branch target buffer.
// The buffer predicts the next PC in fetch and carries the prediction through ID and EX.
// It resolves the prediction in EX and requests a redirect on a wrong direction or target.
// Each entry has a saturating direction counter. Allocation prefers the lowest invalid
// way, otherwise it uses a per-set round-robin pointer.
module btb_assoc #(
  parameter int SET_ADDR_LEN = 6,
  parameter int WAYS         = 2,
  parameter int CTR_W        = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_f,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       br_type_e,
  input  logic             br_taken_e,
  input  logic [31:0]      br_target_e,
  output logic             pred_taken_f,
  output logic [31:0]      pred_target_f,
  output logic [31:0]      pc_e,
  output logic             redirect_e,
  output logic [31:0]      redirect_pc_e,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int SETS  = 1 << SET_ADDR_LEN;
  localparam int TAG_W = 30 - SET_ADDR_LEN;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  // Only the MSB is set, which is the weakly-taken state.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX ^ (CTR_MAX >> 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(WAYS - 1);

  // Saturating up/down step of a direction counter
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
    if (up) begin
      return (c == CTR_MAX) ? c : c + CTR_W'(1);
    end else begin
      return (c == {CTR_W{1'b0}}) ? c : c - CTR_W'(1);
    end
  endfunction

  // Saturating increment of a performance counter
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------- storage
  logic [WAYS-1:0]  valid_r [SETS];
  logic [CTR_W-1:0] ctr_r   [SETS][WAYS];
  logic [TAG_W-1:0] tag_r   [SETS][WAYS];
  logic [31:0]      tgt_r   [SETS][WAYS];
  logic [WAY_W-1:0] rr_r    [SETS];

  // ------------------------------------------------------------ fetch lookup
  logic [SET_ADDR_LEN-1:0] f_set_s;
  logic [TAG_W-1:0]        f_tag_s;
  logic                    f_hit_s;
  logic [WAY_W-1:0]        f_way_s;
  logic [CTR_W-1:0]        f_ctr_s;
  logic [31:0]             f_tgt_s;
  logic                    unused_pc_bits;

  assign f_set_s        = pc_f[SET_ADDR_LEN+1:2];
  assign f_tag_s        = pc_f[31:SET_ADDR_LEN+2];
  assign unused_pc_bits = ^pc_f[1:0];

  // Tag compare across the ways of the fetch set, then form the prediction
  always_comb begin
    f_hit_s = 1'b0;
    f_way_s = {WAY_W{1'b0}};
    f_ctr_s = {CTR_W{1'b0}};
    f_tgt_s = 32'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (!f_hit_s && valid_r[f_set_s][w] && (tag_r[f_set_s][w] == f_tag_s)) begin
        f_hit_s = 1'b1;
        f_way_s = WAY_W'(w);
        f_ctr_s = ctr_r[f_set_s][w];
        f_tgt_s = tgt_r[f_set_s][w];
      end else begin
        f_hit_s = f_hit_s;
      end
    end
    pred_taken_f  = f_hit_s && f_ctr_s[CTR_W-1];
    pred_target_f = pred_taken_f ? f_tgt_s : pc_f + 32'd4;
  end

  // ------------------------------------------------------ ID / EX metadata
  logic [31:0]      id_pc_r,   ex_pc_r;
  logic             id_hit_r,  ex_hit_r;
  logic [WAY_W-1:0] id_way_r,  ex_way_r;
  logic [CTR_W-1:0] id_ctr_r,  ex_ctr_r;
  logic             id_pt_r,   ex_pt_r;
  logic [31:0]      id_ptgt_r, ex_ptgt_r;

  // Advance prediction metadata one stage per unstalled cycle; flush kills predictions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc_r   <= 32'd0;
      id_hit_r  <= 1'b0;
      id_way_r  <= {WAY_W{1'b0}};
      id_ctr_r  <= {CTR_W{1'b0}};
      id_pt_r   <= 1'b0;
      id_ptgt_r <= 32'd0;
      ex_pc_r   <= 32'd0;
      ex_hit_r  <= 1'b0;
      ex_way_r  <= {WAY_W{1'b0}};
      ex_ctr_r  <= {CTR_W{1'b0}};
      ex_pt_r   <= 1'b0;
      ex_ptgt_r <= 32'd0;
    end else if (!stall) begin
      id_pc_r   <= pc_f;
      id_hit_r  <= f_hit_s && !flush;
      id_way_r  <= f_way_s;
      id_ctr_r  <= f_ctr_s;
      id_pt_r   <= pred_taken_f && !flush;
      id_ptgt_r <= pred_target_f;
      ex_pc_r   <= id_pc_r;
      ex_hit_r  <= id_hit_r && !flush;
      ex_way_r  <= id_way_r;
      ex_ctr_r  <= id_ctr_r;
      ex_pt_r   <= id_pt_r && !flush;
      ex_ptgt_r <= id_ptgt_r;
    end
  end

  assign pc_e = ex_pc_r;

  // ------------------------------------------------------------- EX resolve
  logic                    is_br_s;
  logic                    upd_s;
  logic [31:0]             ex_seq_s;
  logic [31:0]             act_s;
  logic [31:0]             prd_s;
  logic [SET_ADDR_LEN-1:0] ex_set_s;
  logic [TAG_W-1:0]        ex_tag_s;

  assign ex_set_s = ex_pc_r[SET_ADDR_LEN+1:2];
  assign ex_tag_s = ex_pc_r[31:SET_ADDR_LEN+2];

  // Compare the actual next PC against the carried prediction
  always_comb begin
    is_br_s  = (br_type_e != 3'd0);
    upd_s    = !stall && is_br_s;
    ex_seq_s = ex_pc_r + 32'd4;
    act_s    = br_taken_e ? br_target_e : ex_seq_s;
    prd_s    = ex_pt_r ? ex_ptgt_r : ex_seq_s;
    if (is_br_s) begin
      redirect_e    = !stall && (act_s != prd_s);
      redirect_pc_e = act_s;
    end else begin
      // A taken prediction on a non-branch is a false hit and falls through.
      redirect_e    = !stall && ex_pt_r;
      redirect_pc_e = ex_seq_s;
    end
  end

  // ------------------------------------------------------- victim selection
  logic [WAY_W-1:0] victim_s;
  logic             free_s;
  logic [WAY_W-1:0] rr_next_s;

  // Lowest invalid way wins; otherwise the set's round-robin pointer picks the victim
  always_comb begin
    victim_s  = rr_r[ex_set_s];
    free_s    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!free_s && !valid_r[ex_set_s][w]) begin
        free_s   = 1'b1;
        victim_s = WAY_W'(w);
      end else begin
        free_s = free_s;
      end
    end
    rr_next_s = (rr_r[ex_set_s] == WAY_LAST) ? {WAY_W{1'b0}} : rr_r[ex_set_s] + WAY_W'(1);
  end

  // Control state of the table: valid bits, direction counters, round-robin pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= {WAYS{1'b0}};
        rr_r[s]    <= {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
          ctr_r[s][w] <= {CTR_W{1'b0}};
        end
      end
    end else if (upd_s) begin
      if (ex_hit_r) begin
        ctr_r[ex_set_s][ex_way_r] <= ctr_step(ex_ctr_r, br_taken_e);
      end else if (br_taken_e) begin
        valid_r[ex_set_s][victim_s] <= 1'b1;
        ctr_r[ex_set_s][victim_s]   <= CTR_INIT;
        rr_r[ex_set_s]              <= rr_next_s;
      end
    end
  end

  // Tag and target payload. It has no reset because it is qualified by valid_r.
  always_ff @(posedge clk) begin
    if (upd_s && br_taken_e) begin
      if (ex_hit_r) begin
        tgt_r[ex_set_s][ex_way_r] <= br_target_e;
      end else begin
        tag_r[ex_set_s][victim_s] <= ex_tag_s;
        tgt_r[ex_set_s][victim_s] <= br_target_e;
      end
    end
  end

  // Saturating counts of resolved branches and redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= {CNT_W{1'b0}};
      miss_cnt <= {CNT_W{1'b0}};
    end else begin
      if (upd_s) begin
        br_cnt <= cnt_inc(br_cnt);
      end
      if (redirect_e) begin
        miss_cnt <= cnt_inc(miss_cnt);
      end
    end
  end

endmodule
